// File: rtl/wb_pkg.sv
// Shared types and bus tag constants for the writeback stage.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } wb_state_t;

  typedef enum logic [1:0] {
    ST_SD = 2'b00,
    ST_SW = 2'b01,
    ST_SH = 2'b10,
    ST_SB = 2'b11
  } store_type_t;

  localparam logic       TAG_WRITE = 1'b0;
  localparam logic       TAG_READ  = 1'b1;
  localparam logic [3:0] TAG_MMIO  = 4'b0011;

  // Tag layout: {direction, space, reserved[5:0], store size}
  function automatic logic [12:0] store_tag(input store_type_t st);
    return {TAG_WRITE, TAG_MMIO, 6'b000000, st};
  endfunction

endpackage

// File: rtl/store_bus_master.sv
// Store sequencer: latches a store in IDLE and issues it as an address beat
// followed by a data beat on the system bus; counts completed stores.
//
// state | meaning
// IDLE  | no store in flight, a store may be accepted
// ADDR  | address beat presented, waiting for ack
// DATA  | data beat presented, waiting for ack
module store_bus_master
  import wb_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      mem_write,
  input  logic [BUS_DATA_WIDTH-1:0] store_addr,
  input  logic [BUS_DATA_WIDTH-1:0] store_data,
  input  logic [1:0]                store_type,
  input  logic                      bus_reqack,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic [31:0]               store_count,
  output wb_state_t                 state
);

  logic [BUS_DATA_WIDTH-1:0] data_q;

  // Bus outputs are loaded from the next state so beats hold steady without ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      data_q      <= '0;
      bus_reqcyc  <= 1'b0;
      bus_req     <= '0;
      bus_reqtag  <= '0;
      store_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_write) begin
            state      <= ADDR;
            data_q     <= store_data;
            bus_reqcyc <= 1'b1;
            bus_req    <= store_addr;
            bus_reqtag <= BUS_TAG_WIDTH'(store_tag(store_type_t'(store_type)));
          end
        end
        ADDR: begin
          if (bus_reqack) begin
            state   <= DATA;
            bus_req <= data_q;
          end
        end
        DATA: begin
          if (bus_reqack) begin
            state       <= IDLE;
            bus_reqcyc  <= 1'b0;
            bus_req     <= '0;
            bus_reqtag  <= '0;
            store_count <= store_count + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: commits results to the register file and hands
// stores to the bus master, stalling upstream while a store is in flight.
module writeback
  import wb_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [4:0]                inDestRegister,
  input  logic                      inRegWrite,
  input  logic                      inMemOrReg,
  input  logic                      inMemWrite,
  input  logic [BUS_DATA_WIDTH-1:0] inResult,
  input  logic [BUS_DATA_WIDTH-1:0] inReadData,
  input  logic [BUS_DATA_WIDTH-1:0] inDataReg2,
  input  logic [1:0]                inStoreType,
  input  logic                      bus_reqack,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      outRegWrEn,
  output logic [4:0]                outRegWrAddr,
  output logic [BUS_DATA_WIDTH-1:0] outRegWrData,
  output logic                      outStall,
  output logic [31:0]               outStoreCount
);

  wb_state_t store_state;

  store_bus_master #(
    .BUS_DATA_WIDTH(BUS_DATA_WIDTH),
    .BUS_TAG_WIDTH (BUS_TAG_WIDTH)
  ) u_store (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_write  (inMemWrite),
    .store_addr (inResult),
    .store_data (inDataReg2),
    .store_type (inStoreType),
    .bus_reqack (bus_reqack),
    .bus_reqcyc (bus_reqcyc),
    .bus_req    (bus_req),
    .bus_reqtag (bus_reqtag),
    .store_count(outStoreCount),
    .state      (store_state)
  );

  assign outStall = (store_state != IDLE);

  // x0 is hardwired to zero, so writes to it are dropped here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outRegWrEn   <= 1'b0;
      outRegWrAddr <= '0;
      outRegWrData <= '0;
    end else begin
      outRegWrEn   <= inRegWrite && (inDestRegister != 5'd0) && !outStall;
      outRegWrAddr <= inDestRegister;
      outRegWrData <= inMemOrReg ? inReadData : inResult;
    end
  end

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed scenarios plus randomized
// traffic compared against a queue-of-beats reference model.
module tb_writeback;

  localparam int DW = 64;
  localparam int TW = 13;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [4:0]    inDestRegister = '0;
  logic          inRegWrite = 1'b0;
  logic          inMemOrReg = 1'b0;
  logic          inMemWrite = 1'b0;
  logic [DW-1:0] inResult = '0;
  logic [DW-1:0] inReadData = '0;
  logic [DW-1:0] inDataReg2 = '0;
  logic [1:0]    inStoreType = '0;
  logic          bus_reqack = 1'b0;
  logic          bus_reqcyc;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          outRegWrEn;
  logic [4:0]    outRegWrAddr;
  logic [DW-1:0] outRegWrData;
  logic          outStall;
  logic [31:0]   outStoreCount;

  writeback #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) dut (
    .clk(clk), .reset_n(reset_n), .inDestRegister(inDestRegister),
    .inRegWrite(inRegWrite), .inMemOrReg(inMemOrReg), .inMemWrite(inMemWrite),
    .inResult(inResult), .inReadData(inReadData), .inDataReg2(inDataReg2),
    .inStoreType(inStoreType), .bus_reqack(bus_reqack), .bus_reqcyc(bus_reqcyc),
    .bus_req(bus_req), .bus_reqtag(bus_reqtag), .outRegWrEn(outRegWrEn),
    .outRegWrAddr(outRegWrAddr), .outRegWrData(outRegWrData), .outStall(outStall),
    .outStoreCount(outStoreCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a store is a queue of pending bus beats; the stage is
  // busy while any beat is outstanding.
  typedef struct {
    logic [DW-1:0] req;
    logic [TW-1:0] tag;
  } beat_t;

  beat_t         beats[$];
  logic [31:0]   m_count;
  logic          m_en;
  logic [4:0]    m_addr;
  logic [DW-1:0] m_data;

  task automatic model_reset();
    beats.delete();
    m_count = '0;
    m_en    = 1'b0;
    m_addr  = '0;
    m_data  = '0;
  endtask

  // Advance one clock: update the model from the inputs the DUT samples,
  // then settle just after the rising edge.
  task automatic tick();
    beat_t b;
    bit busy;
    busy   = (beats.size() != 0);
    m_en   = inRegWrite && (inDestRegister != 5'd0) && !busy;
    m_addr = inDestRegister;
    m_data = inMemOrReg ? inReadData : inResult;
    if (busy) begin
      if (bus_reqack) begin
        b = beats.pop_front();
        if (beats.size() == 0) m_count = m_count + 32'd1;
      end
    end else if (inMemWrite) begin
      b.tag = 13'h0300 | 13'(inStoreType);
      b.req = inResult;
      beats.push_back(b);
      b.req = inDataReg2;
      beats.push_back(b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      inDestRegister = 5'($urandom);
      inRegWrite     = 1'b1;
      inMemOrReg     = 1'($urandom);
      inMemWrite     = 1'b1;
      inResult       = {$urandom, $urandom};
      inReadData     = {$urandom, $urandom};
      inDataReg2     = {$urandom, $urandom};
      inStoreType    = 2'($urandom);
      bus_reqack     = 1'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if ({bus_reqcyc, bus_req, bus_reqtag, outRegWrEn, outRegWrAddr, outRegWrData,
           outStall, outStoreCount} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: cyc=%0b req=%h tag=%h en=%0b addr=%0d data=%h stall=%0b cnt=%0d, required all 0",
                 bus_reqcyc, bus_req, bus_reqtag, outRegWrEn, outRegWrAddr, outRegWrData,
                 outStall, outStoreCount);
      end
    end
    inRegWrite = 1'b0;
    inMemWrite = 1'b0;
    bus_reqack = 1'b0;
    reset_n    = 1'b1;
    tick();
    checks++;
    if (outStall !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_stall: got %0b, required 0", outStall);
    end
  endtask

  task automatic test_reg_write();
    inRegWrite = 1'b1; inDestRegister = 5'd5; inMemOrReg = 1'b0; inResult = 64'h1234;
    tick();
    checks++;
    if ({outRegWrEn, outRegWrAddr, outRegWrData} !== {1'b1, 5'd5, 64'h1234}) begin
      errors++;
      $display("FAIL reg_write: en=%0b addr=%0d data=%h, required 1/5/1234",
               outRegWrEn, outRegWrAddr, outRegWrData);
    end
    inDestRegister = 5'd0;
    tick();
    checks++;
    if (outRegWrEn !== 1'b0) begin
      errors++;
      $display("FAIL reg_write_x0: en=%0b, required 0", outRegWrEn);
    end
    inRegWrite = 1'b0;
  endtask

  task automatic test_load_commit();
    inRegWrite = 1'b1; inDestRegister = 5'd7; inMemOrReg = 1'b1;
    inReadData = 64'hFFFF_FFFF_FFFF_FF80; inResult = 64'h55;
    tick();
    checks++;
    if ({outRegWrEn, outRegWrAddr, outRegWrData} !== {1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FF80}) begin
      errors++;
      $display("FAIL load_commit: en=%0b addr=%0d data=%h, required 1/7/ffffffffffffff80",
               outRegWrEn, outRegWrAddr, outRegWrData);
    end
    inRegWrite = 1'b0; inMemOrReg = 1'b0;
  endtask

  task automatic test_store_immediate();
    bus_reqack = 1'b1; inMemWrite = 1'b1; inStoreType = 2'b01;
    inResult = 64'h8000; inDataReg2 = 64'hDEADBEEF;
    tick();
    inMemWrite = 1'b0;
    checks++;
    if ({bus_reqcyc, bus_req, bus_reqtag, outStall} !== {1'b1, 64'h8000, 13'h0301, 1'b1}) begin
      errors++;
      $display("FAIL store_addr_beat: cyc=%0b req=%h tag=%h stall=%0b, required 1/8000/0301/1",
               bus_reqcyc, bus_req, bus_reqtag, outStall);
    end
    tick();
    checks++;
    if ({bus_reqcyc, bus_req, bus_reqtag, outStall} !== {1'b1, 64'hDEADBEEF, 13'h0301, 1'b1}) begin
      errors++;
      $display("FAIL store_data_beat: cyc=%0b req=%h tag=%h stall=%0b, required 1/deadbeef/0301/1",
               bus_reqcyc, bus_req, bus_reqtag, outStall);
    end
    tick();
    checks++;
    if ({bus_reqcyc, outStall, outStoreCount} !== {1'b0, 1'b0, 32'd1}) begin
      errors++;
      $display("FAIL store_done: cyc=%0b stall=%0b cnt=%0d, required 0/0/1",
               bus_reqcyc, outStall, outStoreCount);
    end
  endtask

  task automatic test_delayed_ack();
    bus_reqack = 1'b0; inMemWrite = 1'b1; inStoreType = 2'b00;
    inResult = 64'h100; inDataReg2 = 64'h55AA;
    tick();
    inMemWrite = 1'b0; inRegWrite = 1'b1; inDestRegister = 5'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({bus_reqcyc, bus_req, bus_reqtag, outStall, outRegWrEn} !==
          {1'b1, 64'h100, 13'h0300, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL delayed_ack_hold[%0d]: cyc=%0b req=%h tag=%h stall=%0b en=%0b, required 1/100/0300/1/0",
                 i, bus_reqcyc, bus_req, bus_reqtag, outStall, outRegWrEn);
      end
    end
    inRegWrite = 1'b0;
    bus_reqack = 1'b1;
    tick();
    checks++;
    if (bus_req !== 64'h55AA) begin
      errors++;
      $display("FAIL delayed_ack_data: req=%h, required 55aa", bus_req);
    end
    tick();
    checks++;
    if ({outStall, outStoreCount} !== {1'b0, 32'd2}) begin
      errors++;
      $display("FAIL delayed_ack_done: stall=%0b cnt=%0d, required 0/2", outStall, outStoreCount);
    end
  endtask

  task automatic test_reset_in_data();
    bus_reqack = 1'b1; inMemWrite = 1'b1; inStoreType = 2'b11;
    inResult = 64'h200; inDataReg2 = 64'h7F;
    tick();
    inMemWrite = 1'b0;
    tick();
    checks++;
    if ({bus_reqcyc, bus_req} !== {1'b1, 64'h7F}) begin
      errors++;
      $display("FAIL reset_in_data_pre: cyc=%0b req=%h, required 1/7f", bus_reqcyc, bus_req);
    end
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus_reqcyc, outStall, outStoreCount} !== {1'b0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_in_data_abort: cyc=%0b stall=%0b cnt=%0d, required 0/0/0",
               bus_reqcyc, outStall, outStoreCount);
    end
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    inMemWrite = 1'b1;
    tick();
    inMemWrite = 1'b0;
    tick();
    tick();
    checks++;
    if ({outStall, outStoreCount} !== {1'b0, 32'd1}) begin
      errors++;
      $display("FAIL reset_in_data_after: stall=%0b cnt=%0d, required 0/1", outStall, outStoreCount);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] stall_seen;
    bus_reqack = 1'b1; inMemWrite = 1'b1;
    for (int i = 0; i < 6; i++) begin
      inResult = {$urandom, $urandom}; inDataReg2 = {$urandom, $urandom};
      inStoreType = 2'($urandom);
      tick();
      stall_seen[5-i] = outStall;
    end
    inMemWrite = 1'b0;
    tick();
    tick();
    checks++;
    if (stall_seen !== 6'b110110) begin
      errors++;
      $display("FAIL back_to_back_stall: got %b, required 110110", stall_seen);
    end
    checks++;
    if (outStoreCount !== m_count) begin
      errors++;
      $display("FAIL back_to_back_count: got %0d, required %0d", outStoreCount, m_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      inDestRegister = 5'($urandom);
      inRegWrite     = 1'($urandom);
      inMemOrReg     = 1'($urandom);
      inMemWrite     = ($urandom_range(0, 3) == 0);
      inResult       = {$urandom, $urandom};
      inReadData     = {$urandom, $urandom};
      inDataReg2     = {$urandom, $urandom};
      inStoreType    = 2'($urandom);
      bus_reqack     = 1'($urandom);
      tick();
      checks++;
      if ({outRegWrEn, outRegWrAddr, outRegWrData} !== {m_en, m_addr, m_data}) begin
        errors++;
        $display("FAIL rand_regpath[%0d]: en=%0b addr=%0d data=%h, required %0b/%0d/%h",
                 i, outRegWrEn, outRegWrAddr, outRegWrData, m_en, m_addr, m_data);
      end
      checks++;
      if ({outStall, bus_reqcyc, outStoreCount} !== {beats.size() != 0, beats.size() != 0, m_count}) begin
        errors++;
        $display("FAIL rand_state[%0d]: stall=%0b cyc=%0b cnt=%0d, required busy=%0b cnt=%0d",
                 i, outStall, bus_reqcyc, outStoreCount, beats.size() != 0, m_count);
      end
      if (beats.size() != 0) begin
        checks++;
        if ({bus_req, bus_reqtag} !== {beats[0].req, beats[0].tag}) begin
          errors++;
          $display("FAIL rand_beat[%0d]: req=%h tag=%h, required %h/%h",
                   i, bus_req, bus_reqtag, beats[0].req, beats[0].tag);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_reg_write();
    test_load_commit();
    test_store_immediate();
    test_delayed_ack();
    test_reset_in_data();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback.md
# writeback

Fifth and final pipeline stage, directly downstream of the data-memory stage. It commits ALU or load results to the register file and performs stores as system-bus write transactions. While a store is in flight it stalls upstream and keeps a free-running count of completed stores.

## Interface
Parameters:
- BUS_DATA_WIDTH, 64, width of data, address and register values
- BUS_TAG_WIDTH, 13, width of bus_reqtag

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- inDestRegister  in  5  destination register index
- inRegWrite  in  1  instruction writes a register
- inMemOrReg  in  1  1 selects inReadData, 0 selects inResult
- inMemWrite  in  1  instruction is a store
- inResult  in  BUS_DATA_WIDTH  ALU result, which is the store address for stores
- inReadData  in  BUS_DATA_WIDTH  sign- or zero-extended load data
- inDataReg2  in  BUS_DATA_WIDTH  store data, already truncated to store size
- inStoreType  in  2  00 sd, 01 sw, 10 sh, 11 sb
- bus_reqack  in  1  bus accepts the current request beat
- bus_reqcyc  out  1  request beat valid
- bus_req  out  BUS_DATA_WIDTH  address beat, then data beat
- bus_reqtag  out  BUS_TAG_WIDTH  request tag
- outRegWrEn  out  1  register-file write enable
- outRegWrAddr  out  5  register-file write index
- outRegWrData  out  BUS_DATA_WIDTH  register-file write data
- outStall  out  1  stage busy; upstream holds its outputs
- outStoreCount  out  32  number of completed stores, wraps

## Operation
- Register path, registered, 1-cycle latency:
  - outRegWrEn <= inRegWrite && inDestRegister != 0 && !outStall.
  - outRegWrAddr <= inDestRegister.
  - outRegWrData <= inMemOrReg ? inReadData : inResult.
  - x0 writes are always suppressed.
- Store FSM, states IDLE, ADDR, DATA:
  - IDLE: if inMemWrite, latch inResult, inDataReg2 and inStoreType, then go to ADDR. This is the only cycle where the store is accepted.
  - ADDR: bus_reqcyc=1, bus_req=address, bus_reqtag = {1'b0 (WRITE), 4'b0011 (MMIO), 6'b0, storeType}. On bus_reqack, go to DATA.
  - DATA: bus_reqcyc=1, bus_req=data, tag unchanged. On bus_reqack, go to IDLE and increment outStoreCount.
- outStall = (state != IDLE), combinational from state.
- inMemWrite is ignored while outStall=1; upstream holds the store until it is accepted, so each store is accepted exactly once.
- A store with inRegWrite=1 performs both actions in the acceptance cycle.
- bus outputs are registered from the next state. While bus_reqack=0, beats are held stable with no change to bus_req or bus_reqtag.
- outStoreCount wraps from 0xFFFFFFFF to 0.

## Timing
- Reset, asynchronous: state=IDLE; every output is 0, including bus_reqcyc, bus_req, bus_reqtag, outRegWr*, outStall and outStoreCount.
- Reset asserted mid-transaction aborts it: bus_reqcyc drops immediately and the latched store is discarded.
- Store accepted at edge N:
  - bus_reqcyc=1 and the address beat are valid after N.
  - With ack at edges N+1 and N+2, the stage is IDLE after N+2.
  - Minimum store occupancy is 2 cycles of stall.
- Ack in the same cycle the beat first appears is legal and advances the FSM.
- A back-to-back store presented while DATA completes is accepted at the first IDLE cycle. There is no bus_reqcyc gap requirement.

## Structure
- Package wb_pkg holds:
  - wb_state_t enum (IDLE, ADDR, DATA).
  - store_type_t enum.
  - Tag constants TAG_WRITE=1'b0, TAG_READ=1'b1, TAG_MMIO=4'b0011.
- Sub-module store_bus_master contains the FSM, the store latches, the bus outputs and the store counter. The top level holds the register-file path and outStall.

## Test plan
- Reset check: hold reset_n=0 and drive random inputs -> all outputs 0. Release reset -> outStall=0.
- Register write: inRegWrite=1, dest=5, inMemOrReg=0, inResult=0x1234 -> next cycle outRegWrEn=1, addr=5, data=0x1234. Repeat with dest=0 -> outRegWrEn=0.
- Load commit: inMemOrReg=1, inReadData=0xFFFF_FFFF_FFFF_FF80, dest=7 -> outRegWrData=0xFFFF_FFFF_FFFF_FF80.
- Store with immediate ack: sw, address 0x8000, data 0xDEADBEEF, bus_reqack tied 1 ->
  - beat 1 is bus_req=0x8000 with tag 0x0301.
  - beat 2 is bus_req=0xDEADBEEF.
  - outStall is high for 2 cycles and outStoreCount=1.
- Delayed ack: hold bus_reqack=0 for 5 cycles in ADDR -> bus_req and bus_reqtag stay stable, outStall stays 1, and a held inRegWrite does not assert outRegWrEn. The store completes normally once ack arrives.
- Reset in DATA: assert reset_n=0 mid-store -> bus_reqcyc=0 at once and outStoreCount=0. After release, a new store completes with count=1.
